// File: rtl/po2_weight_encoder.sv
// Power-of-two weight encoder: turns D signed weights into zero/negative/log2 fields
// using one bit-serial leading-one scan per element, so latency never depends on data.
module po2_weight_encoder #(
    parameter int          W           = 16,
    parameter int          D           = 4,
    parameter int unsigned ZERO_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [D*W-1:0]   packed_w,
    input  logic             in_v,
    output logic             in_rdy,
    output logic [D-1:0]     zero_weights,
    output logic [D-1:0]     negative_weights,
    output logic [D*W-1:0]   log_2_weights,
    output logic             out_v,
    input  logic             out_rdy,
    output logic [2:0]       state_dbg
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int TW = W + 1;
    localparam logic [TW-1:0] THRESH  = TW'(ZERO_THRESH);
    localparam logic [W-1:0]  LOG_MAX = W'(W - 1);
    localparam logic [W-1:0]  ONE     = W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Handshake: a vector moves on an edge where in_v && in_rdy; a result
    // moves on an edge where out_v && out_rdy. Both sides hold until then.

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [D*W-1:0] w_q, w_d;
    logic [W-1:0]   mag_q, mag_d;
    logic           neg_q, neg_d;
    logic [BW-1:0]  b_q, b_d;
    logic           found_q, found_d;
    logic [BW-1:0]  p_q, p_d;
    logic           rnd_q, rnd_d;
    logic [D-1:0]   sh_zero_q, sh_zero_d;
    logic [D-1:0]   sh_neg_q, sh_neg_d;
    logic [D*W-1:0] sh_log_q, sh_log_d;
    logic [D-1:0]   zero_out_q, zero_out_d;
    logic [D-1:0]   neg_out_q, neg_out_d;
    logic [D*W-1:0] log_out_q, log_out_d;

    logic [W-1:0]   cur_w;
    logic [W-1:0]   log_sum;
    logic           enc_zero;
    logic           enc_neg;
    logic [W-1:0]   enc_log;

    always_comb begin
        cur_w = '0;
        for (int j = 0; j < D; j++) begin
            if (idx_q == IW'(j)) begin
                cur_w = w_q[W*(D-1-j) +: W];
            end
        end
    end

    // Encoding of the element just scanned; the clamp guards against p+rnd overflow.
    always_comb begin
        log_sum  = {{(W-BW){1'b0}}, p_q} + {{(W-1){1'b0}}, rnd_q};
        enc_zero = !found_q || ({1'b0, mag_q} < THRESH);
        enc_neg  = enc_zero ? 1'b0 : neg_q;
        if (enc_zero) begin
            enc_log = '0;
        end else if (log_sum > LOG_MAX) begin
            enc_log = LOG_MAX;
        end else begin
            enc_log = log_sum;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        w_d        = w_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        b_d        = b_q;
        found_d    = found_q;
        p_d        = p_q;
        rnd_d      = rnd_q;
        sh_zero_d  = sh_zero_q;
        sh_neg_d   = sh_neg_q;
        sh_log_d   = sh_log_q;
        zero_out_d = zero_out_q;
        neg_out_d  = neg_out_q;
        log_out_d  = log_out_q;

        case (state_q)
            S_IDLE: begin
                if (in_v) begin
                    w_d     = packed_w;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                neg_d   = cur_w[W-1];
                mag_d   = cur_w[W-1] ? ((~cur_w) + ONE) : cur_w;
                b_d     = BW'(W - 1);
                found_d = 1'b0;
                p_d     = '0;
                rnd_d   = 1'b0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (!found_q && mag_q[b_q]) begin
                    found_d = 1'b1;
                    p_d     = b_q;
                    rnd_d   = (b_q != '0) ? mag_q[b_q - 1'b1] : 1'b0;
                end
                if (b_q == '0) begin
                    state_d = S_STORE;
                end else begin
                    b_d = b_q - 1'b1;
                end
            end
            S_STORE: begin
                for (int j = 0; j < D; j++) begin
                    if (idx_q == IW'(j)) begin
                        sh_zero_d[D-1-j]         = enc_zero;
                        sh_neg_d[D-1-j]          = enc_neg;
                        sh_log_d[W*(D-1-j) +: W] = enc_log;
                    end
                end
                if (idx_q == IW'(D - 1)) begin
                    zero_out_d = sh_zero_d;
                    neg_out_d  = sh_neg_d;
                    log_out_d  = sh_log_d;
                    state_d    = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            w_q        <= '0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            b_q        <= '0;
            found_q    <= 1'b0;
            p_q        <= '0;
            rnd_q      <= 1'b0;
            sh_zero_q  <= '0;
            sh_neg_q   <= '0;
            sh_log_q   <= '0;
            zero_out_q <= '0;
            neg_out_q  <= '0;
            log_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            w_q        <= w_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            b_q        <= b_d;
            found_q    <= found_d;
            p_q        <= p_d;
            rnd_q      <= rnd_d;
            sh_zero_q  <= sh_zero_d;
            sh_neg_q   <= sh_neg_d;
            sh_log_q   <= sh_log_d;
            zero_out_q <= zero_out_d;
            neg_out_q  <= neg_out_d;
            log_out_q  <= log_out_d;
        end
    end

    assign in_rdy           = (state_q == S_IDLE);
    assign out_v            = (state_q == S_DONE);
    assign zero_weights     = zero_out_q;
    assign negative_weights = neg_out_q;
    assign log_2_weights    = log_out_q;
    assign state_dbg        = state_q;

endmodule

// File: doc/po2_weight_encoder.md
Name: po2_weight_encoder

Overview:
Converts a vector of D signed fixed-point weights into power-of-two form: zero flag, negative flag and log2 magnitude per element. This is the same encoding the po2 dot-product path consumes from its zero/negative/log_2 weight memories. The block lets weights be re-quantised on chip, so the hex files no longer have to come from an offline script. Elements are encoded one at a time by a bit-serial leading-one scan, so latency is fixed and deterministic.

Parameters:
W, 16, width of each input weight and of each log2 output field
D, 4, number of weights per vector
ZERO_THRESH, 1, magnitudes strictly below this value encode as zero; unsigned, range 0..2^(W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
packed_w  in  D*W  signed weights; element j is packed_w[W*(D-j-1) +: W]
in_v  in  1  input vector valid
in_rdy  out  1  block idle and able to accept a vector
zero_weights  out  D  element j is bit D-1-j; 1 means the weight is zero
negative_weights  out  D  element j is bit D-1-j; 1 means the weight is negative
log_2_weights  out  D*W  element j is slice [W*(D-j-1) +: W]; unsigned exponent p, where |w| ≈ 2^p LSBs
out_v  out  1  result valid
out_rdy  in  1  downstream accepts result

Behaviour:
- Reset, asynchronous and valid in any state:
  - state goes to IDLE, element index goes to 0, and any in-flight job is aborted with no partial result;
  - out_v=0, all packed outputs=0, in_rdy=1.
- States: IDLE, LOAD, SCAN, STORE, DONE.
- IDLE:
  - in_rdy=1; in_rdy is 0 in every other state.
  - When in_v=1 on a clock edge, packed_w is captured, i=0, and the state goes to LOAD.
  - packed_w is ignored after capture.
- LOAD (1 cycle):
  - mag = |w[i]| as a W-bit unsigned value, so -2^(W-1) gives mag=2^(W-1) with no overflow.
  - neg = sign bit of w[i].
  - bit counter b=W-1, found=0, p=0, rnd=0.
  - Next state is SCAN.
- SCAN (exactly W cycles, b = W-1 down to 0):
  - If found=0 and mag[b]=1: found=1, p=b, and rnd=mag[b-1] (rnd=0 when b=0).
  - Later set bits are ignored.
  - After b=0 is processed, the next state is STORE.
- STORE (1 cycle):
  - Zero case, when found=0 or mag<ZERO_THRESH: zero=1, neg=0, log=0.
  - Otherwise: zero=0, neg as captured, log=p+rnd. Rounding is linear: the value rounds up when mag ≥ 1.5·2^p, and ties round up.
  - p+rnd cannot exceed W-1, because mag ≤ 2^(W-1) and bit W-2 is clear whenever p=W-1. The result is still clamped to W-1 defensively.
  - The result is written to internal shadow slot i.
  - If i==D-1, the shadow registers copy to the outputs and the state goes to DONE. Otherwise i increments and the state goes to LOAD.
- DONE:
  - out_v=1.
  - Outputs are held stable while out_v=1 and out_rdy=0.
  - On an edge with out_rdy=1, the state goes to IDLE and out_v drops to 0.
  - Outputs keep their last values until the next DONE entry.
  - in_v present in DONE is not accepted in the same cycle; acceptance happens at the earliest on the following IDLE edge.
- Latency:
  - out_v rises exactly D·(W+2) edges after the acceptance edge, which is 72 for the defaults.
  - The minimum period between vectors is D·(W+2)+2 cycles.
- Per-element latency is independent of data; there is no early exit from SCAN.

Test Plan:
- D=4, W=16, thresh 1. Input {0x0100, 0xFF00, 0x0180, 0x017F} → zero=0000, negative=0100, log={8,8,9,8}. out_v rises 72 edges after accept.
- Input {0x0000, 0xFFFF, 0x0001, 0x0003} → zero=1000, negative=0100, log={0,0,0,2}. 3 = 1.5·2 rounds up.
- Extremes {0x8000, 0x7FFF, 0x6000, 0x4000} → negative=1000, log={15,15,15,14}, no wrap.
- ZERO_THRESH=4, input {3, -4, -3, 4} → zero=1010, negative=0100, log={0,2,0,2}.
- Handshake:
  - Hold out_rdy=0 for 5 cycles after out_v: outputs and out_v stay stable.
  - in_v held high throughout: a second vector is accepted only on the edge after out_rdy completes the transfer, with in_rdy=0 while busy.
- Assert rst during SCAN of element 2: outputs are all 0, out_v=0, in_rdy=1. A fresh vector then completes with correct values in 72 edges.
